// File: rtl/microwave_timer_fsm.sv
// Cook-timer controller: loadable time, prescaled countdown, pause/resume,
// door interlock, cancel and a fixed-length done beep.
module microwave_timer_fsm #(
   parameter int TW       = 8,
   parameter int TICK_DIV = 4,
   parameter int BEEP_LEN = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [TW-1:0] tin,
   input  logic          load,
   input  logic          start,
   input  logic          stop,
   input  logic          door,
   output logic          heat,
   output logic          beep,
   output logic [TW-1:0] remain,
   output logic [1:0]    state
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int BW = (BEEP_LEN > 1) ? $clog2(BEEP_LEN) : 1;
   localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_LEN - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        cur, nxt;
   logic [TW-1:0] rem_q, rem_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [BW-1:0] bc_q, bc_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur   <= IDLE;
         rem_q <= '0;
         pre_q <= '0;
         bc_q  <= '0;
      end else begin
         cur   <= nxt;
         rem_q <= rem_d;
         pre_q <= pre_d;
         bc_q  <= bc_d;
      end
   end

   always_comb begin
      nxt   = cur;
      rem_d = rem_q;
      pre_d = pre_q;
      bc_d  = bc_q;
      case (cur)
         IDLE: begin
            if (stop) begin
               rem_d = '0;
            end else if (load) begin
               rem_d = tin;
            end else if (start && !door && rem_q != '0) begin
               nxt   = RUN;
               pre_d = '0;
            end
         end
         RUN: begin
            // Leaving RUN freezes the prescaler so a resume continues the partial unit.
            if (stop || door) begin
               nxt = PAUSE;
            end else if (pre_q == PRE_LAST) begin
               pre_d = '0;
               if (rem_q <= TW'(1)) begin
                  rem_d = '0;
                  nxt   = DONE;
                  bc_d  = '0;
               end else begin
                  rem_d = rem_q - 1'b1;
               end
            end else begin
               pre_d = pre_q + 1'b1;
            end
         end
         PAUSE: begin
            if (stop) begin
               nxt   = IDLE;
               rem_d = '0;
            end else if (load) begin
               rem_d = tin;
            end else if (start && !door && rem_q != '0) begin
               nxt = RUN;
            end
         end
         DONE: begin
            if (stop) begin
               nxt = IDLE;
            end else if (load) begin
               rem_d = tin;
               nxt   = IDLE;
            end else if (bc_q == BEEP_LAST) begin
               nxt = IDLE;
            end else begin
               bc_d = bc_q + 1'b1;
            end
         end
         default: nxt = IDLE;
      endcase
   end

   assign heat   = (cur == RUN);
   assign beep   = (cur == DONE);
   assign remain = rem_q;
   assign state  = cur;

endmodule

// File: tb/tb_microwave_timer_fsm.sv
// Directed and random stimulus for microwave_timer_fsm, checked every cycle
// against a cycle-level behavioural model of the cook timer.
module tb_microwave_timer_fsm;

   localparam int TW       = 8;
   localparam int TICK_DIV = 4;
   localparam int BEEP_LEN = 3;

   localparam int S_IDLE  = 0;
   localparam int S_RUN   = 1;
   localparam int S_PAUSE = 2;
   localparam int S_DONE  = 3;

   logic          clk;
   logic          rst;
   logic [TW-1:0] tin;
   logic          load, start, stop, door;
   logic          heat, beep;
   logic [TW-1:0] remain;
   logic [1:0]    state;

   int n_asserts = 0;
   int n_fail    = 0;

   // model: mode, time left, cycles elapsed in the current unit, beep cycles left
   int m_mode, m_left, m_elapsed, m_beep_left;
   int cnt_heat, cnt_beep;

   microwave_timer_fsm #(.TW(TW), .TICK_DIV(TICK_DIV), .BEEP_LEN(BEEP_LEN)) dut (
      .clk(clk), .rst(rst), .tin(tin), .load(load), .start(start),
      .stop(stop), .door(door), .heat(heat), .beep(beep),
      .remain(remain), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = S_IDLE; m_left = 0; m_elapsed = 0; m_beep_left = 0;
   endtask

   task automatic model_edge(input bit l, input bit s, input bit p, input bit d, input int t);
      case (m_mode)
         S_IDLE: begin
            if (p) m_left = 0;
            else if (l) m_left = t;
            else if (s && !d && m_left > 0) begin m_mode = S_RUN; m_elapsed = 0; end
         end
         S_RUN: begin
            if (p || d) m_mode = S_PAUSE;
            else begin
               m_elapsed = m_elapsed + 1;
               if (m_elapsed == TICK_DIV) begin
                  m_elapsed = 0;
                  if (m_left > 0) m_left = m_left - 1;
                  if (m_left == 0) begin m_mode = S_DONE; m_beep_left = BEEP_LEN; end
               end
            end
         end
         S_PAUSE: begin
            if (p) begin m_mode = S_IDLE; m_left = 0; end
            else if (l) m_left = t;
            else if (s && !d && m_left > 0) m_mode = S_RUN;
         end
         default: begin
            if (p) m_mode = S_IDLE;
            else if (l) begin m_left = t; m_mode = S_IDLE; end
            else begin
               m_beep_left = m_beep_left - 1;
               if (m_beep_left == 0) m_mode = S_IDLE;
            end
         end
      endcase
   endtask

   task automatic step(input bit l, input bit s, input bit p, input bit d, input int t);
      load = l; start = s; stop = p; door = d; tin = TW'(t);
      @(posedge clk);
      model_edge(l, s, p, d, t);
      #1;
      chk("state",  32'(state),  32'(m_mode));
      chk("remain", 32'(remain), 32'(m_left));
      chk("heat",   32'(heat),   32'(m_mode == S_RUN));
      chk("beep",   32'(beep),   32'(m_mode == S_DONE));
      if (heat === 1'b1) cnt_heat++;
      if (beep === 1'b1) cnt_beep++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b0; tin = '0; load = 0; start = 0; stop = 0; door = 0;
      model_reset();
      #12;
      chk("rst_state",  32'(state),  32'd0);
      chk("rst_remain", 32'(remain), 32'd0);
      chk("rst_heat",   32'(heat),   32'd0);
      chk("rst_beep",   32'(beep),   32'd0);
      @(posedge clk); #1; rst = 1'b1;

      // basic cook: 3 units -> 12 heat cycles, 3 beep cycles
      step(1, 0, 0, 0, 3);
      cnt_heat = 0; cnt_beep = 0;
      step(0, 1, 0, 0, 0);
      idle(20);
      chk("cook_heat_cycles", 32'(cnt_heat), 32'd12);
      chk("cook_beep_cycles", 32'(cnt_beep), 32'd3);
      chk("cook_end_idle",    32'(state),    32'd0);

      // door interlock mid-unit, resume continues the partial unit
      step(1, 0, 0, 0, 5);
      step(0, 1, 0, 0, 0);
      idle(2);
      step(0, 0, 0, 1, 0);
      chk("door_pause", 32'(state),  32'd2);
      chk("door_rem",   32'(remain), 32'd5);
      idle(2);
      step(0, 1, 0, 0, 0);
      idle(1);
      chk("resume_hold", 32'(remain), 32'd5);
      idle(1);
      chk("resume_dec",  32'(remain), 32'd4);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);

      // start refused: empty time, then door open
      step(0, 1, 0, 0, 0);
      chk("refuse_empty", 32'(state), 32'd0);
      step(1, 0, 0, 0, 4);
      step(0, 1, 0, 1, 0);
      chk("refuse_door", 32'(heat), 32'd0);

      // stop pauses in RUN, second stop cancels
      step(1, 0, 0, 0, 7);
      step(0, 1, 0, 0, 0);
      idle(2);
      step(0, 0, 1, 0, 0);
      chk("stop_pause_rem", 32'(remain), 32'd7);
      step(0, 0, 1, 0, 0);
      chk("stop_cancel_rem", 32'(remain), 32'd0);

      // stop in DONE cuts the beep to one cycle
      step(1, 0, 0, 0, 1);
      cnt_beep = 0;
      step(0, 1, 0, 0, 0);
      idle(4);
      step(0, 0, 1, 0, 0);
      chk("done_stop_beep", 32'(cnt_beep), 32'd1);

      // load beats start in IDLE; load ignored in RUN; stop+door pauses
      step(1, 1, 0, 0, 9);
      chk("load_start_rem", 32'(remain), 32'd9);
      chk("load_start_st",  32'(state),  32'd0);
      step(0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 2);
      chk("run_load_ign", 32'(remain), 32'd9);
      step(0, 0, 1, 1, 0);
      chk("stop_door", 32'(state), 32'd2);
      step(0, 0, 1, 0, 0);

      // asynchronous reset between edges in RUN
      step(1, 0, 0, 0, 6);
      step(0, 1, 0, 0, 0);
      idle(3);
      #3 rst = 1'b0;
      #1;
      chk("async_heat",   32'(heat),   32'd0);
      chk("async_state",  32'(state),  32'd0);
      chk("async_remain", 32'(remain), 32'd0);
      model_reset();
      @(posedge clk); #1; rst = 1'b1;

      // maximum load counts down to zero without wrapping
      step(1, 0, 0, 0, 255);
      step(0, 1, 0, 0, 0);
      idle(255 * TICK_DIV);
      chk("max_done",   32'(state),  32'd3);
      chk("max_remain", 32'(remain), 32'd0);
      idle(BEEP_LEN);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 24) == 0, $urandom_range(0, 9) == 0,
              int'($urandom_range(0, 15)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
